// File: rtl/alu_fpu.sv
// alu_fpu: execute-stage datapath for the multi-cycle DLX core.
// - Integer ALU on the GP buses.
// - Integer multiply, or pass-through, on the FP buses.
// - Branch-condition flags.
// Every result is registered once, so the controller sees it one cycle
// after the operands were presented.
module alu_fpu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] fbusA,
    input  logic [WIDTH-1:0] fbusB,
    input  logic             FPUctrl,
    input  logic             isMult,
    output logic [WIDTH-1:0] ALUout,
    output logic [WIDTH-1:0] FPUout,
    output logic             gp_branch,
    output logic             fp_branch
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SEQ  = 4'd8;
    localparam logic [3:0] OP_SNE  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SGT  = 4'd11;
    localparam logic [3:0] OP_SLE  = 4'd12;
    localparam logic [3:0] OP_SGE  = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_LHI  = 4'd15;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0]   and_vec;
    logic [WIDTH-1:0]   or_vec;
    logic [WIDTH-1:0]   xor_vec;
    logic [4:0]         shamt;
    logic               eq_flag;
    logic               lt_signed;
    logic               lt_unsigned;
    logic [WIDTH-1:0]   alu_next;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   unused_prod_hi;
    logic [WIDTH-1:0]   fpu_next;
    logic [WIDTH-1:0]   alu_out_reg;
    logic [WIDTH-1:0]   fpu_out_reg;
    logic               gp_branch_reg;
    logic               fp_branch_reg;

    // Bitwise logic operations, built one bit slice at a time.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_vec[gi] = busA[gi] & busB[gi];
            assign or_vec[gi]  = busA[gi] | busB[gi];
            assign xor_vec[gi] = busA[gi] ^ busB[gi];
        end
    endgenerate

    // Shifts use only the low five bits of B; the upper bits are ignored.
    assign shamt       = busB[4:0];
    assign eq_flag     = (busA == busB);
    assign lt_signed   = ($signed(busA) < $signed(busB));
    assign lt_unsigned = (busA < busB);

    // ALU result select; every encoding is defined, so nothing can go X.
    always_comb begin
        alu_next = ZERO;
        unique case (ALUctrl)
            OP_ADD:  alu_next = busA + busB;
            OP_SUB:  alu_next = busA - busB;
            OP_AND:  alu_next = and_vec;
            OP_OR:   alu_next = or_vec;
            OP_XOR:  alu_next = xor_vec;
            OP_SLL:  alu_next = busA << shamt;
            OP_SRL:  alu_next = busA >> shamt;
            OP_SRA:  alu_next = $unsigned($signed(busA) >>> shamt);
            OP_SEQ:  alu_next = eq_flag ? ONE : ZERO;
            OP_SNE:  alu_next = eq_flag ? ZERO : ONE;
            OP_SLT:  alu_next = lt_signed ? ONE : ZERO;
            OP_SGT:  alu_next = (!lt_signed && !eq_flag) ? ONE : ZERO;
            OP_SLE:  alu_next = (lt_signed || eq_flag) ? ONE : ZERO;
            OP_SGE:  alu_next = lt_signed ? ZERO : ONE;
            OP_SLTU: alu_next = lt_unsigned ? ONE : ZERO;
            OP_LHI:  alu_next = {busB[15:0], {(WIDTH-16){1'b0}}};
            default: alu_next = ZERO;
        endcase
    end

    // Operand extension follows MULT/MULTU so the full 64-bit product is
    // correct, even though only the low word is exported today.
    assign ext_a          = FPUctrl ? {{WIDTH{1'b0}}, fbusA} : {{WIDTH{fbusA[WIDTH-1]}}, fbusA};
    assign ext_b          = FPUctrl ? {{WIDTH{1'b0}}, fbusB} : {{WIDTH{fbusB[WIDTH-1]}}, fbusB};
    assign product        = ext_a * ext_b;
    assign unused_prod_hi = product[2*WIDTH-1:WIDTH];

    // FPU result select: multiply low word or pass-through of operand A.
    always_comb begin
        fpu_next = fbusA;
        if (isMult) begin
            fpu_next = product[WIDTH-1:0];
        end
    end

    // Output registers; reset clears all of them and overrides any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_reg   <= ZERO;
            fpu_out_reg   <= ZERO;
            gp_branch_reg <= 1'b0;
            fp_branch_reg <= 1'b0;
        end else begin
            alu_out_reg   <= alu_next;
            fpu_out_reg   <= fpu_next;
            gp_branch_reg <= (busA == ZERO);
            fp_branch_reg <= (fbusA != ZERO);
        end
    end

    assign ALUout    = alu_out_reg;
    assign FPUout    = fpu_out_reg;
    assign gp_branch = gp_branch_reg;
    assign fp_branch = fp_branch_reg;

endmodule

// File: tb/tb_alu_fpu.sv
// Directed testbench for alu_fpu with hand-computed expected values.
module tb_alu_fpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [3:0]  ALUctrl;
    logic [31:0] fbusA;
    logic [31:0] fbusB;
    logic        FPUctrl;
    logic        isMult;
    logic [31:0] ALUout;
    logic [31:0] FPUout;
    logic        gp_branch;
    logic        fp_branch;

    int total = 0;
    int bad   = 0;

    alu_fpu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .busA      (busA),
        .busB      (busB),
        .ALUctrl   (ALUctrl),
        .fbusA     (fbusA),
        .fbusB     (fbusB),
        .FPUctrl   (FPUctrl),
        .isMult    (isMult),
        .ALUout    (ALUout),
        .FPUout    (FPUout),
        .gp_branch (gp_branch),
        .fp_branch (fp_branch)
    );

    always #5 clk = ~clk;

    // One comparison: count it and print one line per transaction.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctrl, input logic [31:0] exp_v);
        busA    = a;
        busB    = b;
        ALUctrl = ctrl;
        step();
        check(tag, ALUout, exp_v);
    endtask

    task automatic fpu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input logic mul, input logic [31:0] exp_v);
        fbusA   = a;
        fbusB   = b;
        FPUctrl = uns;
        isMult  = mul;
        step();
        check(tag, FPUout, exp_v);
    endtask

    initial begin
        reset   = 1'b1;
        busA    = 32'h1234_5678;
        busB    = 32'h0000_0003;
        ALUctrl = 4'd0;
        fbusA   = 32'h0000_0009;
        fbusB   = 32'h0000_0005;
        FPUctrl = 1'b0;
        isMult  = 1'b1;
        step();
        check("reset_alu", ALUout, 32'h0);
        check("reset_fpu", FPUout, 32'h0);
        check("reset_gp",  {31'h0, gp_branch}, 32'h0);
        check("reset_fp",  {31'h0, fp_branch}, 32'h0);
        reset = 1'b0;

        // Multiply
        fpu_op("mul_s_2x8",      32'd2,    32'd8,           1'b0, 1'b1, 32'd16);
        fpu_op("mul_s_2xm8",     32'd2,    32'hFFFF_FFF8,   1'b0, 1'b1, 32'hFFFF_FFF0);
        fpu_op("mul_u_2xm8",     32'd2,    32'hFFFF_FFF8,   1'b1, 1'b1, 32'hFFFF_FFF0);
        fpu_op("mul_s_35xm8",    32'd35,   32'hFFFF_FFF8,   1'b0, 1'b1, 32'hFFFF_FEE8);
        fpu_op("mul_s_1000x2000",32'd1000, 32'd2000,        1'b0, 1'b1, 32'd2000000);
        fpu_op("mul_u_ffxff",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0001);
        fpu_op("pass_7",         32'd7,    32'd99,          1'b0, 1'b0, 32'd7);
        check("fp_branch_7", {31'h0, fp_branch}, 32'd1);

        // Arithmetic and logic
        alu_op("add",  32'd2,          32'd4,        4'd0,  32'd6);
        alu_op("sub",  32'hFFFF_FFFF,  32'd4,        4'd1,  32'hFFFF_FFFB);
        alu_op("and",  32'hFFFF_FFFF,  32'd4,        4'd2,  32'd4);
        alu_op("or",   32'd28,         32'd4,        4'd3,  32'd28);
        alu_op("xor",  32'd36,         32'd4,        4'd4,  32'd32);
        alu_op("lhi",  32'hDEAD_BEEF,  32'hFFFF_1234, 4'd15, 32'h1234_0000);

        // Shifts, including an over-range amount that wraps to 4
        alu_op("sll",    32'h8000_0010, 32'd4,  4'd5, 32'h0000_0100);
        alu_op("srl",    32'h8000_0010, 32'd4,  4'd6, 32'h0800_0001);
        alu_op("sra",    32'h8000_0010, 32'd4,  4'd7, 32'hF800_0001);
        alu_op("sll_36", 32'h8000_0010, 32'd36, 4'd5, 32'h0000_0100);
        alu_op("sra_36", 32'h8000_0010, 32'd36, 4'd7, 32'hF800_0001);

        // Compares
        alu_op("slt_m1_1",  32'hFFFF_FFFF, 32'd1,  4'd10, 32'd1);
        alu_op("sltu_m1_1", 32'hFFFF_FFFF, 32'd1,  4'd14, 32'd0);
        alu_op("seq_40",    32'd40, 32'd40, 4'd8,  32'd1);
        alu_op("sne_40",    32'd40, 32'd40, 4'd9,  32'd0);
        alu_op("sle_40",    32'd40, 32'd40, 4'd12, 32'd1);
        alu_op("sge_40",    32'd40, 32'd40, 4'd13, 32'd1);
        alu_op("slt_40",    32'd40, 32'd40, 4'd10, 32'd0);
        alu_op("sgt_41",    32'd41, 32'd40, 4'd11, 32'd1);
        alu_op("sgt_40",    32'd40, 32'd40, 4'd11, 32'd0);
        alu_op("sge_m1_1",  32'hFFFF_FFFF, 32'd1, 4'd13, 32'd0);

        // Branch flags appear exactly one cycle after the input change
        busA  = 32'd5;
        fbusA = 32'd3;
        isMult = 1'b0;
        step();
        check("gp_busA5", {31'h0, gp_branch}, 32'd0);
        busA  = 32'd0;
        fbusA = 32'd0;
        #2;
        check("gp_hold", {31'h0, gp_branch}, 32'd0);
        check("fp_hold", {31'h0, fp_branch}, 32'd1);
        step();
        check("gp_busA0", {31'h0, gp_branch}, 32'd1);
        check("fp_fbusA0", {31'h0, fp_branch}, 32'd0);

        // Reset while an operation is presented
        busA    = 32'd7;
        busB    = 32'd9;
        ALUctrl = 4'd0;
        fbusA   = 32'd6;
        fbusB   = 32'd6;
        isMult  = 1'b1;
        step();
        check("pre_rst_alu", ALUout, 32'd16);
        check("pre_rst_fpu", FPUout, 32'd36);
        reset = 1'b1;
        step();
        check("rst_alu", ALUout, 32'h0);
        check("rst_fpu", FPUout, 32'h0);
        check("rst_fp",  {31'h0, fp_branch}, 32'h0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_fpu.md
Name: alu_fpu

Overview:
Combined execute-stage datapath for the multi-cycle DLX-style processor.
- Integer ALU on the GP register buses (busA/busB).
- Integer multiply unit on the FP register-file buses (fbusA/fbusB).
- Branch-condition flags for GP and FP branches.
- All results are registered once per clock so the multi-cycle controller samples them in the following state.

Parameters:
WIDTH, 32, datapath width of all buses (only 32 is required to be supported)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
busA  input  32  ALU operand A (GP rs1)
busB  input  32  ALU operand B (GP rs2 or immediate)
ALUctrl  input  4  ALU operation select
fbusA  input  32  FPU operand A
fbusB  input  32  FPU operand B
FPUctrl  input  1  multiply signedness: 0 = signed (MULT), 1 = unsigned (MULTU)
isMult  input  1  1 = multiply; 0 = pass fbusA through
ALUout  output  32  registered ALU result
FPUout  output  32  registered FPU result
gp_branch  output  1  registered: 1 when busA == 0
fp_branch  output  1  registered: 1 when fbusA != 0

Behaviour:
- Single clock domain.
- On each rising clk edge with reset=1, all four outputs are cleared to 0; reset overrides any operation in flight.
- Otherwise, outputs load from combinational functions of the inputs present before the edge. Latency is exactly 1 cycle with no handshake; a new operation may be issued every cycle.
- ALUctrl encoding:
  - 0 ADD A+B; 1 SUB A-B (modulo 2^32, no overflow flag).
  - 2 AND; 3 OR; 4 XOR.
  - 5 SLL A<<B[4:0]; 6 SRL logical A>>B[4:0]; 7 SRA arithmetic A>>>B[4:0]. Upper bits of B are ignored.
  - 8 SEQ; 9 SNE; 10 SLT; 11 SGT; 12 SLE; 13 SGE. These are signed compares; result is 32'd1 when true, 32'd0 when false.
  - 14 SLTU: unsigned A<B, result 1/0.
  - 15 LHI: {B[15:0],16'h0000}.
- FPU:
  - isMult=1: 64-bit product of fbusA and fbusB. Operands are sign-extended when FPUctrl=0 and zero-extended when FPUctrl=1. FPUout receives the low 32 bits.
  - The low 32 bits are identical for both signedness modes; FPUctrl still selects the extension mode so a future high-word output is correct.
  - isMult=0: FPUout <= fbusA.
- gp_branch <= (busA==32'd0), independent of ALUctrl; the controller inverts it for BNEZ.
- fp_branch <= (fbusA!=32'd0), i.e. the FP status is true; used for BFPT/BFPF.
- Mid-operation reset: no state other than the output registers exists, so reset simply clears them.
- X-free: every ALUctrl value is defined; no latches.

Test Plan:
- Reset: assert reset 1 cycle with arbitrary inputs -> ALUout=0, FPUout=0, gp_branch=0, fp_branch=0 after the edge.
- Multiply, signed (isMult=1, FPUctrl=0), one result per edge:
  - fbusA=2, fbusB=8 -> FPUout=16.
  - fbusB=-8 -> FPUout=32'hFFFFFFF0 (-16).
  - FPUctrl=1 -> FPUout=32'hFFFFFFF0.
- Multiply, further values:
  - fbusA=35, fbusB=-8 -> 32'hFFFFFEE8.
  - fbusA=1000, fbusB=2000 -> 2000000.
  - isMult=0, fbusA=7 -> FPUout=7 and fp_branch=1.
- Arithmetic/logic:
  - A=2, B=4, ctrl 0 -> 6.
  - A=-1, ctrl 1 -> -5.
  - ctrl 2 -> 4.
  - A=28, ctrl 3 -> 28.
  - A=36, ctrl 4 -> 32.
  - ctrl 15, B=16'h1234 -> 32'h12340000.
- Shifts:
  - A=32'h80000010, B=4: ctrl 5 -> 32'h00000100; ctrl 6 -> 32'h08000001; ctrl 7 -> 32'hF8000001.
  - B=36 behaves as shift 4.
- Compares:
  - A=-1, B=1: ctrl 10 -> 1; ctrl 14 -> 0.
  - A=40, B=40: ctrl 8 -> 1, ctrl 9 -> 0, ctrl 12 -> 1, ctrl 13 -> 1.
  - A=41, B=40: ctrl 11 -> 1.
- Branch flags:
  - busA=0 -> gp_branch=1; busA=5 -> gp_branch=0.
  - fbusA=0 -> fp_branch=0.
  - Each flag appears one cycle after the input change.
